sha_nonce_scheduler: RTL and testbench

SHA_NONCE_SCHEDULER -- requirements
Module: sha_nonce_scheduler

---
 rtl/sha_nonce_scheduler_if.sv | 42 ++++
 rtl/sha_nonce_scheduler.sv | 159 +++++++++++++++
 tb/tb_sha_nonce_scheduler.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha_nonce_scheduler_if.sv
// Bundles the job, hash-core and shared-memory signals of the nonce scheduler.
// slave = scheduler side, master = host/core/memory side.
interface sha_nonce_scheduler_if;
    logic        start;
    logic [31:0] nonce_start;
    logic [15:0] nonce_count;
    logic [31:0] target;
    logic [15:0] message_addr;
    logic [15:0] output_addr;
    logic        busy;
    logic        done;
    logic        found;
    logic [31:0] found_nonce;
    logic [31:0] found_hash;
    logic        core_start;
    logic [15:0] core_message_addr;
    logic [15:0] core_output_addr;
    logic        core_done;
    logic        core_mem_we;
    logic [15:0] core_mem_addr;
    logic [31:0] core_mem_write_data;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  start, nonce_start, nonce_count, target, message_addr, output_addr,
        input  core_done, core_mem_we, core_mem_addr, core_mem_write_data, mem_read_data,
        output busy, done, found, found_nonce, found_hash,
        output core_start, core_message_addr, core_output_addr,
        output mem_we, mem_addr, mem_write_data
    );

    modport master (
        output start, nonce_start, nonce_count, target, message_addr, output_addr,
        output core_done, core_mem_we, core_mem_addr, core_mem_write_data, mem_read_data,
        input  busy, done, found, found_nonce, found_hash,
        input  core_start, core_message_addr, core_output_addr,
        input  mem_we, mem_addr, mem_write_data
    );
endinterface

// File: rtl/sha_nonce_scheduler.sv
// Nonce search scheduler: writes each candidate nonce into the message block, runs the
// hash core, reads back hash word 0 and stops on the first hash below target.
module sha_nonce_scheduler #(
    parameter logic [15:0] NONCE_OFFSET = 16'd19
) (
    input  logic                  clk,
    input  logic                  reset,
    sha_nonce_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, WNONCE, LAUNCH, WAIT, RADDR, RLAT, CHECK, FIN} state_t;

    state_t      state, state_next;
    logic [31:0] cur_nonce, cur_nonce_next;
    logic [15:0] tried, tried_next;
    logic [15:0] count_q, count_next;
    logic [15:0] msg_q, msg_next;
    logic [15:0] out_q, out_next;
    logic [31:0] target_q, target_next;
    logic [1:0]  guard, guard_next;
    logic        busy_q, busy_next;
    logic        done_q, done_next;
    logic        found_q, found_next;
    logic [31:0] found_nonce_q, found_nonce_next;
    logic [31:0] found_hash_q, found_hash_next;
    logic        core_start_q, core_start_next;
    logic        sched_we, sched_we_next;
    logic [15:0] sched_addr, sched_addr_next;
    logic [31:0] sched_data, sched_data_next;
    logic        hit;
    logic        core_owns;

    assign hit = bus.mem_read_data < target_q;

    always_comb begin
        state_next       = state;
        cur_nonce_next   = cur_nonce;
        tried_next       = tried;
        count_next       = count_q;
        msg_next         = msg_q;
        out_next         = out_q;
        target_next      = target_q;
        guard_next       = (guard != 2'd0) ? guard - 2'd1 : 2'd0;
        found_next       = found_q;
        found_nonce_next = found_nonce_q;
        found_hash_next  = found_hash_q;
        sched_we_next    = 1'b0;
        sched_addr_next  = sched_addr;
        sched_data_next  = sched_data;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    cur_nonce_next   = bus.nonce_start;
                    tried_next       = 16'd0;
                    count_next       = bus.nonce_count;
                    msg_next         = bus.message_addr;
                    out_next         = bus.output_addr;
                    target_next      = bus.target;
                    found_next       = 1'b0;
                    found_nonce_next = 32'd0;
                    found_hash_next  = 32'd0;
                    state_next       = (bus.nonce_count != 16'd0) ? WNONCE : FIN;
                end
            end
            WNONCE: begin
                // Guard spans LAUNCH and the first WAIT cycle, so a core that drops
                // done late is never mistaken for one that has already finished.
                guard_next = 2'd2;
                state_next = LAUNCH;
            end
            LAUNCH: state_next = WAIT;
            WAIT: begin
                if (guard == 2'd0 && bus.core_done) state_next = RADDR;
            end
            RADDR: state_next = RLAT;
            RLAT:  state_next = CHECK;
            CHECK: begin
                tried_next = tried + 16'd1;
                if (hit) begin
                    found_next       = 1'b1;
                    found_nonce_next = cur_nonce;
                    found_hash_next  = bus.mem_read_data;
                    state_next       = FIN;
                end else if (tried + 16'd1 == count_q) begin
                    state_next = FIN;
                end else begin
                    cur_nonce_next = cur_nonce + 32'd1;
                    state_next     = WNONCE;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Memory drivers are decoded from the next state so they line up with it.
        if (state_next == WNONCE) begin
            sched_we_next   = 1'b1;
            sched_addr_next = msg_next + NONCE_OFFSET;
            sched_data_next = cur_nonce_next;
        end else if (state_next == RADDR) begin
            sched_addr_next = out_q;
        end

        busy_next       = (state_next != IDLE);
        core_start_next = (state_next == LAUNCH);
        done_next       = (state == FIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            guard         <= 2'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            found_nonce_q <= 32'd0;
            found_hash_q  <= 32'd0;
            core_start_q  <= 1'b0;
            sched_we      <= 1'b0;
            sched_addr    <= 16'd0;
            sched_data    <= 32'd0;
        end else begin
            state         <= state_next;
            guard         <= guard_next;
            busy_q        <= busy_next;
            done_q        <= done_next;
            found_q       <= found_next;
            found_nonce_q <= found_nonce_next;
            found_hash_q  <= found_hash_next;
            core_start_q  <= core_start_next;
            sched_we      <= sched_we_next;
            sched_addr    <= sched_addr_next;
            sched_data    <= sched_data_next;
        end
    end

    always_ff @(posedge clk) begin
        cur_nonce <= cur_nonce_next;
        tried     <= tried_next;
        count_q   <= count_next;
        msg_q     <= msg_next;
        out_q     <= out_next;
        target_q  <= target_next;
    end

    assign core_owns = (state == LAUNCH) || (state == WAIT);

    assign bus.mem_we            = core_owns ? bus.core_mem_we         : sched_we;
    assign bus.mem_addr          = core_owns ? bus.core_mem_addr       : sched_addr;
    assign bus.mem_write_data    = core_owns ? bus.core_mem_write_data : sched_data;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.found             = found_q;
    assign bus.found_nonce       = found_nonce_q;
    assign bus.found_hash        = found_hash_q;
    assign bus.core_start        = core_start_q;
    assign bus.core_message_addr = msg_q;
    assign bus.core_output_addr  = out_q;
endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Bench for sha_nonce_scheduler: memory + hash-core models, table vectors, corner
// sequences and randomized jobs checked against a search-loop reference.
module tb_sha_nonce_scheduler;
    localparam logic [15:0] OFF = 16'd19;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sha_nonce_scheduler_if bus();
    sha_nonce_scheduler #(.NONCE_OFFSET(OFF)) dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // hash model: mode 0 = one chosen nonce gets hit_hash, mode 1 = scrambled
    int          hmode = 0;
    logic [31:0] hit_nonce = 32'd0;
    logic [31:0] hit_hash = 32'd0;

    function automatic logic [31:0] hfun(input logic [31:0] n);
        logic [31:0] x;
        if (hmode == 0) return (n == hit_nonce) ? hit_hash : 32'hFFFF_0000;
        x = n * 32'h9E37_79B1;
        x = x ^ (x >> 15);
        x = x * 32'h85EB_CA6B;
        x = x ^ (x >> 13);
        return x;
    endfunction

    // shared synchronous memory
    logic [31:0] mem [0:65535];
    logic [31:0] rd;
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = 16'd0;
    logic [31:0] pre_data = 32'd0;
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_write_data;
        rd <= mem[bus.mem_addr];
    end
    assign bus.mem_read_data = rd;

    // hash core model: hashes the nonce found in memory, writes word 0 just before done
    int          lat = 3;
    logic        stuck = 1'b0;
    logic        force_core = 1'b0;
    int          cnt;
    logic        c_done, c_we;
    logic [31:0] c_hash;
    logic [15:0] core_naddr;
    assign core_naddr = bus.core_message_addr + OFF;
    always @(posedge clk) begin
        if (reset) begin
            cnt <= 0; c_done <= 1'b1; c_we <= 1'b0;
        end else if (stuck) begin
            cnt <= 0; c_done <= 1'b1; c_we <= 1'b0;
        end else if (bus.core_start) begin
            cnt <= lat; c_done <= 1'b0; c_we <= 1'b0;
            c_hash <= hfun(mem[core_naddr]);
        end else if (cnt != 0) begin
            cnt  <= cnt - 1;
            c_we <= (cnt == 2);
            if (cnt == 1) c_done <= 1'b1;
        end
    end
    assign bus.core_done           = c_done;
    assign bus.core_mem_we         = force_core | c_we;
    assign bus.core_mem_addr       = force_core ? 16'hAAAA : bus.core_output_addr;
    assign bus.core_mem_write_data = force_core ? 32'hDEAD_BEEF : c_hash;

    // monitor
    int          cyc = 0, launches = 0, last_launch = 0, launch_gap = 0;
    int          any_writes = 0, other_writes = 0, base_bad = 0;
    logic [15:0] exp_waddr = 16'd0, cur_msg = 16'd0, cur_out = 16'd0;
    logic [31:0] wq[$];
    initial forever begin
        @(negedge clk);
        cyc++;
        if (bus.core_start) begin
            if (launches > 0) launch_gap = cyc - last_launch;
            last_launch = cyc;
            launches++;
        end
        if (bus.mem_we) begin
            any_writes++;
            if (bus.mem_addr == exp_waddr) wq.push_back(bus.mem_write_data);
            else if (bus.mem_addr != cur_out) other_writes++;
        end
        if (bus.busy && (bus.core_message_addr != cur_msg || bus.core_output_addr != cur_out))
            base_bad++;
    end

    task automatic clear_monitor();
        launches = 0; launch_gap = 0; any_writes = 0; other_writes = 0; base_bad = 0;
        wq.delete();
    endtask

    int job_cycles;

    task automatic run_job(input logic [31:0] ns, input logic [15:0] nc, input logic [31:0] tg,
                           input logic [15:0] ma, input logic [15:0] oa, input int glitch_at);
        @(posedge clk); #1;
        bus.nonce_start = ns; bus.nonce_count = nc; bus.target = tg;
        bus.message_addr = ma; bus.output_addr = oa;
        cur_msg = ma; cur_out = oa; exp_waddr = ma + OFF;
        clear_monitor();
        bus.start = 1'b1;
        job_cycles = 0;
        do begin
            @(posedge clk); #1;
            job_cycles++;
            if (job_cycles == 1) bus.start = 1'b0;
            if (glitch_at > 0 && job_cycles == glitch_at) begin
                bus.start = 1'b1; bus.nonce_start = 32'h9000_0000; bus.nonce_count = 16'd1;
                bus.target = 32'hFFFF_FFFF; bus.message_addr = 16'h3000;
            end
            if (glitch_at > 0 && job_cycles == glitch_at + 10) bus.start = 1'b0;
        end while (!bus.done && job_cycles < 3000);
        check("done_seen", bus.done, 1'b1);
    endtask

    task automatic check_job(input string tag, input logic ef, input logic [31:0] efn,
                             input logic [31:0] efh, input int el, input logic [31:0] ns);
        int bad = 0;
        check({tag, "_found"}, bus.found, ef);
        check({tag, "_found_nonce"}, bus.found_nonce, efn);
        check({tag, "_found_hash"}, bus.found_hash, efh);
        check({tag, "_launches"}, launches, el);
        check({tag, "_nonce_writes"}, wq.size(), el);
        foreach (wq[i]) if (wq[i] !== ns + 32'(i)) bad++;
        check({tag, "_nonce_sequence_errors"}, bad, 0);
        check({tag, "_stray_writes"}, other_writes, 0);
        check({tag, "_core_bases"}, base_bad, 0);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, bus.done, 1'b0);
        check({tag, "_idle_after"}, bus.busy, 1'b0);
    endtask

    typedef struct {
        logic [31:0] ns; logic [15:0] nc; logic [31:0] tg; logic [15:0] ma; logic [15:0] oa;
        logic [31:0] hn; logic [31:0] hh;
        logic ef; logic [31:0] efn; logic [31:0] efh; int el;
    } vec_t;
    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        mf;
        logic [31:0] mfn, mfh, rns, rtg, h;
        logic [15:0] rnc, rma;
        int          ml;

        vecs[0] = '{32'd5,         16'd3, 32'd0,         16'h0100, 16'h0200, 32'd0,     32'd0,     1'b0, 32'd0,         32'd0,         3};
        vecs[1] = '{32'h100,       16'd4, 32'h100,       16'h0100, 16'h0200, 32'h101,   32'h10,    1'b1, 32'h101,       32'h10,        2};
        vecs[2] = '{32'hFFFF_FFFF, 16'd2, 32'd0,         16'h0100, 16'h0200, 32'd0,     32'd0,     1'b0, 32'd0,         32'd0,         2};
        vecs[3] = '{32'd0,         16'd0, 32'd0,         16'h0100, 16'h0200, 32'd0,     32'd0,     1'b0, 32'd0,         32'd0,         0};
        vecs[4] = '{32'hFFFF_FFFE, 16'd5, 32'hFFFF_0001, 16'h0400, 16'h0500, 32'd0,     32'd0,     1'b1, 32'hFFFF_FFFE, 32'hFFFF_0000, 1};
        vecs[5] = '{32'd7,         16'd2, 32'h10,        16'h0100, 16'h0200, 32'd8,     32'h10,    1'b0, 32'd0,         32'd0,         2};
        vecs[6] = '{32'd9,         16'd1, 32'd0,         16'hFFF0, 16'h0040, 32'd0,     32'd0,     1'b0, 32'd0,         32'd0,         1};
        vecs[7] = '{32'h20,        16'd3, 32'h11,        16'h0100, 16'h0200, 32'h22,    32'h10,    1'b1, 32'h22,        32'h10,        3};

        bus.start = 1'b0; bus.nonce_start = 32'd0; bus.nonce_count = 16'd0; bus.target = 32'd0;
        bus.message_addr = 16'd0; bus.output_addr = 16'd0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_found", bus.found, 1'b0);
        check("rst_found_nonce", bus.found_nonce, 32'd0);
        check("rst_found_hash", bus.found_hash, 32'd0);
        check("rst_core_start", bus.core_start, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 16'd0);
        check("rst_mem_write_data", bus.mem_write_data, 32'd0);
        reset = 1'b0;

        hmode = 0; lat = 3;
        for (int i = 0; i < 8; i++) begin
            hit_nonce = vecs[i].hn; hit_hash = vecs[i].hh;
            run_job(vecs[i].ns, vecs[i].nc, vecs[i].tg, vecs[i].ma, vecs[i].oa, 0);
            if (vecs[i].nc == 16'd0) check("zero_count_done_latency", job_cycles, 2);
            check_job($sformatf("vec%0d", i), vecs[i].ef, vecs[i].efn, vecs[i].efh, vecs[i].el, vecs[i].ns);
        end

        // start pulses while busy must not disturb the running job
        hit_nonce = 32'h55; hit_hash = 32'h1; lat = 8;
        run_job(32'h50, 16'd8, 32'h2, 16'h0100, 16'h0200, 6);
        check_job("glitch", 1'b1, 32'h55, 32'h1, 6, 32'h50);
        repeat (5) @(posedge clk);
        #1;
        check("hold_found", bus.found, 1'b1);
        check("hold_found_nonce", bus.found_nonce, 32'h55);
        check("hold_found_hash", bus.found_hash, 32'h1);

        // reset while the core is running
        lat = 20;
        @(posedge clk); #1;
        bus.nonce_start = 32'd1; bus.nonce_count = 16'd3; bus.target = 32'd0;
        bus.message_addr = 16'h0100; bus.output_addr = 16'h0200;
        cur_msg = 16'h0100; cur_out = 16'h0200; exp_waddr = 16'h0100 + OFF;
        bus.start = 1'b1;
        job_cycles = 0;
        do begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            job_cycles++;
        end while (!bus.core_start && job_cycles < 50);
        check("midjob_launch_seen", bus.core_start, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1; force_core = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_core_start", bus.core_start, 1'b0);
        check("midrst_mem_we_scheduler_owns", bus.mem_we, 1'b0);
        check("midrst_mem_addr_scheduler_owns", bus.mem_addr, 16'd0);
        check("midrst_found", bus.found, 1'b0);
        reset = 1'b0; force_core = 1'b0;
        @(posedge clk); #1;
        clear_monitor();
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_launches", launches, 0);
        check("post_rst_writes", any_writes, 0);
        check("post_rst_busy", bus.busy, 1'b0);

        // core_done stuck high: the guard alone sets the WAIT length
        stuck = 1'b1;
        @(posedge clk); #1;
        pre_we = 1'b1; pre_addr = 16'h0200; pre_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        pre_we = 1'b0;
        run_job(32'h10, 16'd2, 32'h100, 16'h0100, 16'h0200, 0);
        check("stuck_launch_spacing", launch_gap, 7);
        check_job("stuck_miss", 1'b0, 32'd0, 32'd0, 2, 32'h10);
        pre_we = 1'b1; pre_addr = 16'h0200; pre_data = 32'h50;
        @(posedge clk); #1;
        pre_we = 1'b0;
        run_job(32'h10, 16'd3, 32'h100, 16'h0100, 16'h0200, 0);
        check_job("stuck_hit", 1'b1, 32'h10, 32'h50, 1, 32'h10);
        stuck = 1'b0;

        // randomized jobs against a plain search loop
        hmode = 1;
        for (int j = 0; j < 25; j++) begin
            rns = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
            rnc = 16'($urandom_range(0, 6));
            rtg = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 3));
            rma = 16'($urandom);
            lat = $urandom_range(2, 6);
            mf = 1'b0; mfn = 32'd0; mfh = 32'd0; ml = 0;
            for (int k = 0; k < int'(rnc); k++) begin
                h = hfun(rns + 32'(k));
                ml++;
                if (h < rtg) begin
                    mf = 1'b1; mfn = rns + 32'(k); mfh = h;
                    break;
                end
            end
            run_job(rns, rnc, rtg, rma, rma + 16'h0800, 0);
            check_job($sformatf("rnd%0d", j), mf, mfn, mfh, ml, rns);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
